// File: rtl/snn_mem_pkg.sv
// Shared constants, state encoding and saturation helper for the SNN layer datapath.
// Contents:
//   ADDR_W, DATA_W, ACC_W, FRAC_BITS, KMAX  - datapath sizing
//   DIM_W, KDIM_W                            - widths of map and kernel dimension fields
//   conv_state_t                             - convolution engine FSM states
//   sat16()                                  - clamp an accumulator value to the signed 16-bit range
package snn_mem_pkg;

  localparam int ADDR_W    = 12;
  localparam int DATA_W    = 16;
  localparam int ACC_W     = 40;
  localparam int FRAC_BITS = 8;
  localparam int KMAX      = 7;
  localparam int DIM_W     = 6;
  localparam int KDIM_W    = 3;

  localparam logic signed [ACC_W-1:0] SAT_MAX = 40'sd32767;
  localparam logic signed [ACC_W-1:0] SAT_MIN = -40'sd32768;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SETUP = 3'd1,
    MAC   = 3'd2,
    DRAIN = 3'd3,
    WRITE = 3'd4
  } conv_state_t;

  function automatic logic signed [DATA_W-1:0] sat16(input logic signed [ACC_W-1:0] v);
    logic signed [DATA_W-1:0] res;
    if (v > SAT_MAX) begin
      res = 16'sh7fff;
    end else if (v < SAT_MIN) begin
      res = 16'sh8000;
    end else begin
      res = v[DATA_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/conv_mac_sat.sv
// Multiply-accumulate with Q-format rescale, saturation and optional ReLU.
// Ports:
//   clk, reset   - clock, synchronous active-high reset
//   clear_i      - load the accumulator with zero this cycle
//   en_i         - add a_i*b_i into the accumulator this cycle
//   a_i, b_i     - signed operands
//   relu_en_i    - clamp negative results to zero
//   result_o     - sat(acc_next >>> FRAC_BITS), ReLU applied after saturation
// result_o is derived from the next accumulator value, so the cycle that folds in
// the final product can also capture the finished output.
module conv_mac_sat
  import snn_mem_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_i,
  input  logic                     en_i,
  input  logic signed [DATA_W-1:0] a_i,
  input  logic signed [DATA_W-1:0] b_i,
  input  logic                     relu_en_i,
  output logic signed [DATA_W-1:0] result_o
);

  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_d;
  logic signed [ACC_W-1:0]    shifted;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [DATA_W-1:0]   sat_val;

  // Next accumulator value and the rescaled/saturated result derived from it.
  always_comb begin
    prod  = a_i * b_i;
    acc_d = acc_q;
    if (clear_i) begin
      acc_d = '0;
    end else if (en_i) begin
      acc_d = acc_q + $signed({{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod});
    end else begin
      acc_d = acc_q;
    end
    shifted  = acc_d >>> FRAC_BITS;
    sat_val  = sat16(shifted);
    result_o = (relu_en_i && sat_val[DATA_W-1]) ? '0 : sat_val;
  end

  // Accumulator register.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/conv2d_engine.sv
// Valid-mode, stride-1 2D convolution of one signed Q8 feature map with one KxK kernel.
// Ports:
//   clk, reset                         - clock, synchronous active-high reset
//   start / done                       - run request (sampled in IDLE) / 1 when idle
//   relu_en                            - clamp negative outputs to zero
//   src_start_address, src_row_size,
//   src_col_size                       - input map base, rows (H), cols (W, also row stride)
//   src_address / src_readdata         - input read port, data one cycle after address
//   kern_start_address, kern_size      - kernel base and side K (row-major KxK)
//   kern_address / kern_readdata       - kernel read port, data one cycle after address
//   dest_start_address                 - output map base
//   dest_address, dest_writedata,
//   dest_write_en                      - output write port, one strobe per output, row-major
module conv2d_engine
  import snn_mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              done,
  input  logic              relu_en,
  input  logic [ADDR_W-1:0] src_start_address,
  input  logic [DIM_W-1:0]  src_row_size,
  input  logic [DIM_W-1:0]  src_col_size,
  output logic [ADDR_W-1:0] src_address,
  input  logic [DATA_W-1:0] src_readdata,
  input  logic [ADDR_W-1:0] kern_start_address,
  input  logic [KDIM_W-1:0] kern_size,
  output logic [ADDR_W-1:0] kern_address,
  input  logic [DATA_W-1:0] kern_readdata,
  input  logic [ADDR_W-1:0] dest_start_address,
  output logic [ADDR_W-1:0] dest_address,
  output logic [DATA_W-1:0] dest_writedata,
  output logic              dest_write_en
);

  conv_state_t       state_q;
  logic              done_q, we_q, relu_q;
  logic [DATA_W-1:0] wd_q;
  logic [ADDR_W-1:0] src_addr_q, kern_addr_q, dest_addr_q;
  logic [ADDR_W-1:0] src_base_q, kern_base_q, dest_base_q;
  logic [DIM_W-1:0]  h_q, w_q, oh_q, ow_q, r_q, c_q;
  logic [KDIM_W-1:0] k_q, i_q, j_q;

  logic              tap_last, out_last, k_bad, mac_clear, mac_en;
  logic [KDIM_W-1:0] i_nx, j_nx;
  logic [DIM_W-1:0]  r_nx, c_nx;
  logic signed [DATA_W-1:0] mac_result;

  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [DIM_W-1:0]  row,
                                                  input logic [DIM_W-1:0]  stride,
                                                  input logic [DIM_W-1:0]  col);
    return base + ADDR_W'(row) * ADDR_W'(stride) + ADDR_W'(col);
  endfunction

  // Next kernel tap (j fastest), next output position (c fastest) and size check.
  always_comb begin
    tap_last = (i_q == k_q - 3'd1) && (j_q == k_q - 3'd1);
    if (j_q == k_q - 3'd1) begin
      j_nx = '0;
      i_nx = i_q + 3'd1;
    end else begin
      j_nx = j_q + 3'd1;
      i_nx = i_q;
    end
    out_last = (r_q == oh_q - 6'd1) && (c_q == ow_q - 6'd1);
    if (c_q == ow_q - 6'd1) begin
      c_nx = '0;
      r_nx = r_q + 6'd1;
    end else begin
      c_nx = c_q + 6'd1;
      r_nx = r_q;
    end
    k_bad = (k_q == 3'd0) || ({1'b0, k_q} > 4'(KMAX)) ||
            ({3'b0, k_q} > h_q) || ({3'b0, k_q} > w_q);
    // Read data lags the address by one cycle: the first MAC cycle of an output has
    // nothing valid to add, so it clears; DRAIN adds the last tap.
    mac_clear = (state_q == MAC) && (i_q == 3'd0) && (j_q == 3'd0);
    mac_en    = ((state_q == MAC) && !mac_clear) || (state_q == DRAIN);
  end

  conv_mac_sat u_mac (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (mac_clear),
    .en_i      (mac_en),
    .a_i       ($signed(src_readdata)),
    .b_i       ($signed(kern_readdata)),
    .relu_en_i (relu_q),
    .result_o  (mac_result)
  );

  // Control FSM, tap/output counters, address generators and write register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      done_q      <= 1'b1;
      we_q        <= 1'b0;
      wd_q        <= '0;
      relu_q      <= 1'b0;
      src_addr_q  <= src_start_address;
      kern_addr_q <= kern_start_address;
      dest_addr_q <= dest_start_address;
      src_base_q  <= '0;
      kern_base_q <= '0;
      dest_base_q <= '0;
      h_q  <= '0;  w_q  <= '0;  oh_q <= '0;  ow_q <= '0;
      r_q  <= '0;  c_q  <= '0;  k_q  <= '0;  i_q  <= '0;  j_q <= '0;
    end else begin
      we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q     <= SETUP;
            done_q      <= 1'b0;
            relu_q      <= relu_en;
            src_base_q  <= src_start_address;
            kern_base_q <= kern_start_address;
            dest_base_q <= dest_start_address;
            h_q         <= src_row_size;
            w_q         <= src_col_size;
            k_q         <= kern_size;
          end
        end
        SETUP: begin
          r_q <= '0;
          c_q <= '0;
          i_q <= '0;
          j_q <= '0;
          if (k_bad) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            oh_q        <= h_q - {3'b0, k_q} + 6'd1;
            ow_q        <= w_q - {3'b0, k_q} + 6'd1;
            src_addr_q  <= src_base_q;
            kern_addr_q <= kern_base_q;
            state_q     <= MAC;
          end
        end
        MAC: begin
          if (tap_last) begin
            state_q <= DRAIN;
          end else begin
            i_q         <= i_nx;
            j_q         <= j_nx;
            src_addr_q  <= map_addr(src_base_q, r_q + {3'b0, i_nx}, w_q, c_q + {3'b0, j_nx});
            kern_addr_q <= map_addr(kern_base_q, {3'b0, i_nx}, {3'b0, k_q}, {3'b0, j_nx});
          end
        end
        DRAIN: begin
          state_q     <= WRITE;
          we_q        <= 1'b1;
          wd_q        <= mac_result;
          dest_addr_q <= map_addr(dest_base_q, r_q, ow_q, c_q);
        end
        WRITE: begin
          if (out_last) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
          end else begin
            r_q         <= r_nx;
            c_q         <= c_nx;
            i_q         <= '0;
            j_q         <= '0;
            src_addr_q  <= map_addr(src_base_q, r_nx, w_q, c_nx);
            kern_addr_q <= kern_base_q;
            state_q     <= MAC;
          end
        end
        default: begin
          state_q <= IDLE;
          done_q  <= 1'b1;
        end
      endcase
    end
  end

  assign done           = done_q;
  assign src_address    = src_addr_q;
  assign kern_address   = kern_addr_q;
  assign dest_address   = dest_addr_q;
  assign dest_writedata = wd_q;
  assign dest_write_en  = we_q;

endmodule

// File: tb/tb_conv2d_engine.sv
// Randomized and directed bench for conv2d_engine. A reference model computes every
// expected output from the convolution definition and queues it; a separate monitor
// compares each DUT write against the queue head.
module tb_conv2d_engine;

  logic        clk, reset, start, done, relu_en, dest_write_en;
  logic [11:0] src_start_address, src_address, kern_start_address, kern_address;
  logic [11:0] dest_start_address, dest_address;
  logic [5:0]  src_row_size, src_col_size;
  logic [2:0]  kern_size;
  logic [15:0] src_readdata, kern_readdata, dest_writedata;

  logic [15:0] src_mem  [0:4095];
  logic [15:0] kern_mem [0:4095];

  int checks = 0;
  int errors = 0;
  int exp_addr_q[$];
  int exp_data_q[$];
  int sb, kb, db;

  conv2d_engine dut (
    .clk(clk), .reset(reset), .start(start), .done(done), .relu_en(relu_en),
    .src_start_address(src_start_address), .src_row_size(src_row_size),
    .src_col_size(src_col_size), .src_address(src_address), .src_readdata(src_readdata),
    .kern_start_address(kern_start_address), .kern_size(kern_size),
    .kern_address(kern_address), .kern_readdata(kern_readdata),
    .dest_start_address(dest_start_address), .dest_address(dest_address),
    .dest_writedata(dest_writedata), .dest_write_en(dest_write_en)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous read memories with one cycle of latency.
  always @(posedge clk) begin
    src_readdata  <= src_mem[src_address];
    kern_readdata <= kern_mem[kern_address];
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Monitor: every write strobe must match the next expected output.
  always @(negedge clk) begin
    if (dest_write_en === 1'b1) begin
      if (exp_data_q.size() == 0) begin
        chk("unexpected_write_addr", longint'(dest_address), -1);
      end else begin
        chk("write_addr", longint'(dest_address), longint'(exp_addr_q.pop_front()));
        chk("write_data", longint'($signed(dest_writedata)), longint'(exp_data_q.pop_front()));
      end
    end
  end

  // mode 0: constant val, 1: ramp (r*16+c)*256, 2: random
  task automatic fill_src(input int h, input int w, input int mode, input int val);
    for (int r = 0; r < h; r++)
      for (int c = 0; c < w; c++)
        src_mem[(sb + r*w + c) % 4096] = (mode == 0) ? 16'(val) :
                                         (mode == 1) ? 16'((r*16 + c) * 256) : 16'($urandom);
  endtask

  // mode 0: constant val, 1: centre tap val and rest zero, 2: random
  task automatic fill_kern(input int k, input int mode, input int val);
    for (int i = 0; i < k; i++)
      for (int j = 0; j < k; j++)
        kern_mem[(kb + i*k + j) % 4096] = (mode == 0) ? 16'(val) :
                                          (mode == 1) ? ((i == k/2 && j == k/2) ? 16'(val) : 16'd0) :
                                          16'($urandom);
  endtask

  function automatic bit k_valid(input int h, input int w, input int k);
    return (k >= 1) && (k <= 7) && (k <= h) && (k <= w);
  endfunction

  // Reference convolution; queues at most 'limit' outputs in row-major order.
  task automatic model_push(input int h, input int w, input int k, input bit relu, input int limit);
    int oh, ow, n;
    longint acc, v;
    n = 0;
    if (k_valid(h, w, k)) begin
      oh = h - k + 1;
      ow = w - k + 1;
      for (int r = 0; r < oh; r++)
        for (int c = 0; c < ow; c++) begin
          acc = 0;
          for (int i = 0; i < k; i++)
            for (int j = 0; j < k; j++)
              acc += longint'($signed(src_mem[(sb + (r+i)*w + c + j) % 4096])) *
                     longint'($signed(kern_mem[(kb + i*k + j) % 4096]));
          v = acc >>> 8;
          if (v > 32767) v = 32767;
          if (v < -32768) v = -32768;
          if (relu && v < 0) v = 0;
          if (n < limit) begin
            exp_addr_q.push_back((db + r*ow + c) % 4096);
            exp_data_q.push_back(int'(v));
          end
          n++;
        end
    end
  endtask

  task automatic drive_start(input int h, input int w, input int k, input bit relu);
    src_start_address  = 12'(sb);
    kern_start_address = 12'(kb);
    dest_start_address = 12'(db);
    src_row_size = 6'(h);
    src_col_size = 6'(w);
    kern_size    = 3'(k);
    relu_en      = relu;
    start        = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Full run: model, start, bounded wait for done, latency and completeness checks.
  task automatic run_conv(input string name, input int h, input int w, input int k, input bit relu);
    int cyc, exp_cyc;
    model_push(h, w, k, relu, 1 << 20);
    exp_cyc = k_valid(h, w, k) ? 1 + (h-k+1)*(w-k+1)*(k*k+2) : 1;
    drive_start(h, w, k, relu);
    chk({name, "_busy"}, longint'(done), 0);
    cyc = 0;
    while (done !== 1'b1 && cyc < 20000) begin
      @(posedge clk);
      #1;
      cyc++;
      if (cyc == 1) begin
        src_row_size = 6'($urandom); src_col_size = 6'($urandom); kern_size = 3'($urandom);
        src_start_address = 12'($urandom); kern_start_address = 12'($urandom);
        dest_start_address = 12'($urandom); relu_en = 1'($urandom);
      end
    end
    chk({name, "_cycles"}, cyc, exp_cyc);
    chk({name, "_pending"}, exp_data_q.size(), 0);
    exp_addr_q.delete();
    exp_data_q.delete();
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int h, w, k, kmax;
    for (int a = 0; a < 4096; a++) begin
      src_mem[a] = 16'd0;
      kern_mem[a] = 16'd0;
    end
    start = 1'b0; relu_en = 1'b0; reset = 1'b1;
    src_start_address = 12'h0a5; kern_start_address = 12'h1b6; dest_start_address = 12'h2c7;
    src_row_size = 6'd3; src_col_size = 6'd3; kern_size = 3'd2;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_done", longint'(done), 1);
    chk("reset_we", longint'(dest_write_en), 0);
    chk("reset_wdata", longint'(dest_writedata), 0);
    chk("reset_src_addr", longint'(src_address), 'h0a5);
    chk("reset_kern_addr", longint'(kern_address), 'h1b6);
    chk("reset_dest_addr", longint'(dest_address), 'h2c7);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // Directed cases.
    sb = 16; kb = 200; db = 300;
    fill_src(3, 3, 0, 256);    fill_kern(2, 0, 256);  run_conv("t1_basic", 3, 3, 2, 1'b0);
    fill_src(3, 3, 0, 32767);  fill_kern(1, 0, 512);  run_conv("t2_satpos", 3, 3, 1, 1'b0);
    fill_src(3, 3, 0, -32768); run_conv("t2_satneg", 3, 3, 1, 1'b0);
    fill_src(3, 3, 0, 100);    fill_kern(1, 0, -256); run_conv("t3_relu", 3, 3, 1, 1'b1);
    run_conv("t3_norelu", 3, 3, 1, 1'b0);
    run_conv("t4_k4", 3, 3, 4, 1'b0);
    run_conv("t4_k0", 3, 3, 0, 1'b0);
    sb = 40; kb = 90; db = 500;
    fill_src(4, 6, 1, 0);      fill_kern(3, 1, 256);  run_conv("t5_shift", 4, 6, 3, 1'b0);

    // Reset during the second output's MAC phase.
    sb = 16; kb = 200; db = 300;
    fill_src(3, 3, 0, 256);    fill_kern(2, 0, 256);
    model_push(3, 3, 2, 1'b0, 1);
    drive_start(3, 3, 2, 1'b0);
    repeat (9) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("t6_done_after_reset", longint'(done), 1);
    chk("t6_we_after_reset", longint'(dest_write_en), 0);
    repeat (30) @(posedge clk);
    #1;
    chk("t6_pending", exp_data_q.size(), 0);
    chk("t6_idle", longint'(done), 1);
    exp_addr_q.delete();
    exp_data_q.delete();
    run_conv("t6_rerun", 3, 3, 2, 1'b0);

    // Randomized shapes, data, bases and ReLU.
    for (int n = 0; n < 12; n++) begin
      h = $urandom_range(1, 9);
      w = $urandom_range(1, 9);
      kmax = (h < w) ? h : w;
      if (kmax > 7) kmax = 7;
      k = $urandom_range(1, kmax);
      sb = $urandom_range(0, 1000);
      kb = $urandom_range(0, 1000);
      db = $urandom_range(0, 1000);
      fill_src(h, w, 2, 0);
      fill_kern(k, 2, 0);
      run_conv("rand", h, w, k, 1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
